// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: synchronizes columns, steps rows on a divided
// scan tick, debounces single-key presses/releases and reports a 4-bit key code.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held
);

  // state      | meaning
  // S_SCAN     | rows rotate each tick, looking for exactly one low column
  // S_DEBOUNCE | row frozen, candidate column must persist DEBOUNCE ticks
  // S_PRESSED  | key accepted and held; new keys ignored
  // S_RELEASE  | columns all high, counting ticks to accept the release
  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       col_s1, col_s2;
  logic [3:0]       cand, cand_n;
  logic [3:0]       cnt, cnt_n, cnt_inc;
  logic [3:0]       row_n, row_rot;
  logic [3:0]       code_n;
  logic             valid_n, rel_n;
  logic             all_high, one_low;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  endfunction

  assign tick     = (div_cnt == DIV_LAST);
  assign all_high = (col_s2 == 4'hF);
  assign one_low  = (col_s2 == 4'b1110) || (col_s2 == 4'b1101) ||
                    (col_s2 == 4'b1011) || (col_s2 == 4'b0111);
  assign row_rot  = {row_out[2:0], row_out[3]};
  assign cnt_inc  = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign key_held = (state == S_PRESSED) || (state == S_RELEASE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_s1  <= 4'hF;
      col_s2  <= 4'hF;
      div_cnt <= '0;
    end else begin
      col_s1  <= col_in;
      col_s2  <= col_s1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_SCAN;
      row_out     <= 4'b1110;
      cand        <= 4'hF;
      cnt         <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      row_out     <= row_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_release <= rel_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row_out;
    cand_n  = cand;
    cnt_n   = cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    rel_n   = 1'b0;
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (one_low) begin
            cand_n  = col_s2;
            cnt_n   = 4'd0;
            state_n = S_DEBOUNCE;
          end else begin
            row_n = row_rot;
          end
        end
        S_DEBOUNCE: begin
          if (col_s2 == cand) begin
            if (cnt_inc >= DEB_N) begin
              code_n  = {low_idx(row_out), low_idx(cand)};
              valid_n = 1'b1;
              cnt_n   = 4'd0;
              state_n = S_PRESSED;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = 4'd0;
            row_n   = row_rot;
            state_n = S_SCAN;
          end
        end
        S_PRESSED: begin
          if (all_high) begin
            cnt_n   = 4'd1;
            state_n = S_RELEASE;
          end
        end
        S_RELEASE: begin
          // >= lets DEBOUNCE=1 still release, since the count enters at 1
          if (all_high) begin
            if (cnt_inc >= DEB_N) begin
              rel_n   = 1'b1;
              cnt_n   = 4'd0;
              row_n   = row_rot;
              state_n = S_SCAN;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = 4'd0;
            state_n = S_PRESSED;
          end
        end
        default: state_n = S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives col_in from row_out,
// expected key codes/releases are queued at stimulus time and popped on DUT pulses.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out, key_code;
  logic       key_valid, key_release, key_held;

  logic       key_down = 1'b0;
  logic [3:0] key_row = 4'hF, key_col = 4'hF;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_val = 4'hF;

  int tests = 0;
  int fails = 0;
  int row_changes = 0;
  logic [3:0] prev_row;
  logic [3:0] exp_code_q[$];
  logic       exp_rel_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    if (ovr_en) col_in = ovr_val;
    else if (key_down && row_out == key_row) col_in = key_col;
  end

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (row_out != prev_row) begin
        row_changes++;
        prev_row = row_out;
      end
      if (key_valid) begin
        check("valid_release_overlap", {7'd0, key_release}, 8'd0);
        if (exp_code_q.size() == 0) check("spurious_valid", {7'd0, key_valid}, 8'd0);
        else check("valid_code", {4'd0, key_code}, {4'd0, exp_code_q.pop_front()});
      end
      if (key_release) begin
        if (exp_rel_q.size() == 0) check("spurious_release", {7'd0, key_release}, 8'd0);
        else check("release_pulse", {7'd0, key_release}, {7'd0, exp_rel_q.pop_front()});
      end
    end
  endtask

  initial begin
    logic [3:0] exp_rows [4];
    logic [3:0] r0;
    int cyc;
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // reset and idle row rotation
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_row", {4'd0, row_out}, 8'h0E);
    check("rst_valid", {7'd0, key_valid}, 8'd0);
    check("rst_release", {7'd0, key_release}, 8'd0);
    check("rst_held", {7'd0, key_held}, 8'd0);
    check("rst_code", {4'd0, key_code}, 8'd0);
    prev_row = row_out;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0 = row_out;
      cyc = 0;
      while (row_out == r0 && cyc < 12) begin
        step(1);
        cyc++;
      end
      check("row_step", {4'd0, row_out}, {4'd0, exp_rows[i]});
      check("row_period", 8'(cyc), 8'd4);
    end

    // clean press at row 2, column 1
    key_row = 4'b1011; key_col = 4'b1101;
    exp_code_q.push_back(4'b1001);
    key_down = 1'b1;
    step(80);
    check("press_count", 8'(exp_code_q.size()), 8'd0);
    check("press_held", {7'd0, key_held}, 8'd1);
    check("press_code", {4'd0, key_code}, 8'h09);
    exp_rel_q.push_back(1'b1);
    key_down = 1'b0;
    step(40);
    check("release_count", 8'(exp_rel_q.size()), 8'd0);
    check("release_held", {7'd0, key_held}, 8'd0);
    check("code_holds", {4'd0, key_code}, 8'h09);

    // one-tick bounce: no press, scanning resumes right after
    row_changes = 0;
    ovr_en = 1'b1; ovr_val = 4'b0111;
    step(4);
    ovr_en = 1'b0;
    step(20);
    check("bounce_row_steps", 8'(row_changes), 8'd5);
    check("bounce_held", {7'd0, key_held}, 8'd0);

    // ghosting: two columns low never debounces
    row_changes = 0;
    ovr_en = 1'b1; ovr_val = 4'b1100;
    step(48);
    ovr_en = 1'b0;
    check("ghost_row_steps", 8'(row_changes), 8'd12);
    check("ghost_held", {7'd0, key_held}, 8'd0);
    step(8);

    // release glitch at row 3, column 0
    key_row = 4'b0111; key_col = 4'b1110;
    exp_code_q.push_back(4'b1100);
    key_down = 1'b1;
    step(80);
    check("press2_count", 8'(exp_code_q.size()), 8'd0);
    check("press2_code", {4'd0, key_code}, 8'h0C);
    key_down = 1'b0;
    step(4);
    key_down = 1'b1;
    step(40);
    check("glitch_held", {7'd0, key_held}, 8'd1);
    check("glitch_code", {4'd0, key_code}, 8'h0C);

    // reset while pressed, key still down
    reset = 1'b0;
    step(2);
    check("midrst_held", {7'd0, key_held}, 8'd0);
    check("midrst_row", {4'd0, row_out}, 8'h0E);
    check("midrst_code", {4'd0, key_code}, 8'd0);
    reset = 1'b1;
    exp_code_q.push_back(4'b1100);
    step(80);
    check("repress_count", 8'(exp_code_q.size()), 8'd0);
    check("repress_held", {7'd0, key_held}, 8'd1);
    check("repress_code", {4'd0, key_code}, 8'h0C);
    exp_rel_q.push_back(1'b1);
    key_down = 1'b0;
    step(40);
    check("release2_count", 8'(exp_rel_q.size()), 8'd0);
    check("release2_held", {7'd0, key_held}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
